// File: rtl/pcileech_ft245_dev_pkg.sv
// Shared constants and types for the FT245 synchronous-FIFO device model.
package pcileech_ft245_dev_pkg;

  localparam int unsigned FT_DEPTH_LOG2_DEF = 6;
  localparam int unsigned FT_SIWU_BATCH     = 16;

  typedef logic [7:0] ft_byte_t;

endpackage

// File: rtl/pcileech_ft245_dev_fifo.sv
// Synchronous show-ahead byte FIFO: head visible while count != 0, count and next-count exported.
module pcileech_ft245_dev_fifo
  import pcileech_ft245_dev_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FT_DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  ft_byte_t            push_dat_i,
  input  logic                pop_i,
  output ft_byte_t            head_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic [DEPTH_LOG2:0] count_next_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  ft_byte_t              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty, full;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = count_q[DEPTH_LOG2];
  assign do_pop  = pop_i && !empty;
  // A push into a full FIFO is only taken when a real pop frees the slot on the same edge.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (do_push && !do_pop)      count_d = count_q + (DEPTH_LOG2+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/pcileech_ft245_dev.sv
// FT245 synchronous-FIFO device: host<->master byte FIFOs with registered bus flags,
// optional SIWU-gated batching toward the host, transfer counters and a sticky protocol error.
module pcileech_ft245_dev
  import pcileech_ft245_dev_pkg::*;
#(
  parameter int unsigned PARAM_DEPTH_LOG2 = FT_DEPTH_LOG2_DEF,
  parameter bit          PARAM_SIWU_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ft245_data_in,
  output logic [7:0]  ft245_data_out,
  output logic        ft245_data_oe,
  output logic        ft245_rxf_n,
  output logic        ft245_txe_n,
  input  logic        ft245_rd_n,
  input  logic        ft245_wr_n,
  input  logic        ft245_oe_n,
  input  logic        ft245_siwu_n,
  input  logic [7:0]  host_rx_data,
  input  logic        host_rx_valid,
  output logic        host_rx_ready,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_valid,
  input  logic        host_tx_ready,
  output logic [31:0] cnt_rd,
  output logic [31:0] cnt_wr,
  output logic        err_proto
);

  localparam int unsigned          DEPTH     = 1 << PARAM_DEPTH_LOG2;
  localparam logic [PARAM_DEPTH_LOG2:0] TXE_LVL   = (PARAM_DEPTH_LOG2+1)'(DEPTH - 1);
  localparam logic [PARAM_DEPTH_LOG2:0] BATCH_LVL = (PARAM_DEPTH_LOG2+1)'(FT_SIWU_BATCH);

  ft_byte_t                  rx_head, tx_head;
  logic [PARAM_DEPTH_LOG2:0] rx_count, rx_count_next;
  logic [PARAM_DEPTH_LOG2:0] tx_count, tx_count_next;
  logic                      rx_push, rx_pop, tx_push, tx_pop;
  logic                      tx_release;

  logic        rxf_n_q, rxf_n_d;
  logic        txe_n_q, txe_n_d;
  logic        data_oe_q, data_oe_d;
  logic        flush_q, flush_d;
  logic        err_q, err_d;
  logic [31:0] cnt_rd_q, cnt_rd_d;
  logic [31:0] cnt_wr_q, cnt_wr_d;

  assign host_rx_ready = !rx_count[PARAM_DEPTH_LOG2];
  assign rx_push       = host_rx_valid && host_rx_ready;
  assign rx_pop        = !ft245_rd_n && !ft245_oe_n && !rxf_n_q;
  assign tx_push       = !ft245_wr_n && !txe_n_q;
  assign tx_pop        = host_tx_valid && host_tx_ready;

  pcileech_ft245_dev_fifo #(.DEPTH_LOG2(PARAM_DEPTH_LOG2)) u_rx_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (rx_push),
    .push_dat_i   (host_rx_data),
    .pop_i        (rx_pop),
    .head_o       (rx_head),
    .count_o      (rx_count),
    .count_next_o (rx_count_next)
  );

  pcileech_ft245_dev_fifo #(.DEPTH_LOG2(PARAM_DEPTH_LOG2)) u_tx_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (tx_push),
    .push_dat_i   (ft245_data_in),
    .pop_i        (tx_pop),
    .head_o       (tx_head),
    .count_o      (tx_count),
    .count_next_o (tx_count_next)
  );

  // Without SIWU batching the host sees every byte as soon as it lands.
  generate
    if (PARAM_SIWU_EN) begin : g_siwu
      assign tx_release = (tx_count >= BATCH_LVL) || flush_q;
    end else begin : g_nosiwu
      assign tx_release = 1'b1;
    end
  endgenerate

  assign host_tx_valid = (tx_count != '0) && tx_release;
  assign host_tx_data  = tx_head;

  // Gate the unreset storage so the bus reads zero whenever nothing is buffered.
  assign ft245_data_out = (rx_count == '0) ? 8'h00 : rx_head;

  always_comb begin
    rxf_n_d   = (rx_count_next == '0);
    txe_n_d   = (tx_count_next == TXE_LVL) || tx_count_next[PARAM_DEPTH_LOG2];
    data_oe_d = !ft245_oe_n;
    cnt_rd_d  = cnt_rd_q + (rx_pop  ? 32'd1 : 32'd0);
    cnt_wr_d  = cnt_wr_q + (tx_push ? 32'd1 : 32'd0);

    flush_d = flush_q;
    if (PARAM_SIWU_EN && !ft245_siwu_n) flush_d = 1'b1;
    else if (tx_count_next == '0)       flush_d = 1'b0;

    err_d = err_q
          | (!ft245_rd_n &&  ft245_oe_n)
          | (!ft245_rd_n && !ft245_wr_n)
          | (!ft245_wr_n && !ft245_oe_n)
          | (!ft245_wr_n &&  txe_n_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b1;
      data_oe_q <= 1'b0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
    end else begin
      rxf_n_q   <= rxf_n_d;
      txe_n_q   <= txe_n_d;
      data_oe_q <= data_oe_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      cnt_rd_q  <= cnt_rd_d;
      cnt_wr_q  <= cnt_wr_d;
    end
  end

  assign ft245_rxf_n   = rxf_n_q;
  assign ft245_txe_n   = txe_n_q;
  assign ft245_data_oe = data_oe_q;
  assign err_proto     = err_q;
  assign cnt_rd        = cnt_rd_q;
  assign cnt_wr        = cnt_wr_q;

endmodule

// File: tb/tb_pcileech_ft245_dev.sv
// Directed bench for pcileech_ft245_dev with default parameters (64 B FIFOs, SIWU batching on).
module tb_pcileech_ft245_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ft245_data_in = 8'h00;
  logic [7:0]  ft245_data_out;
  logic        ft245_data_oe;
  logic        ft245_rxf_n;
  logic        ft245_txe_n;
  logic        ft245_rd_n = 1'b1;
  logic        ft245_wr_n = 1'b1;
  logic        ft245_oe_n = 1'b1;
  logic        ft245_siwu_n = 1'b1;
  logic [7:0]  host_rx_data = 8'h00;
  logic        host_rx_valid = 1'b0;
  logic        host_rx_ready;
  logic [7:0]  host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready = 1'b0;
  logic [31:0] cnt_rd;
  logic [31:0] cnt_wr;
  logic        err_proto;

  int n_checks = 0;
  int n_fail   = 0;

  pcileech_ft245_dev dut (
    .clk            (clk),
    .rst            (rst),
    .ft245_data_in  (ft245_data_in),
    .ft245_data_out (ft245_data_out),
    .ft245_data_oe  (ft245_data_oe),
    .ft245_rxf_n    (ft245_rxf_n),
    .ft245_txe_n    (ft245_txe_n),
    .ft245_rd_n     (ft245_rd_n),
    .ft245_wr_n     (ft245_wr_n),
    .ft245_oe_n     (ft245_oe_n),
    .ft245_siwu_n   (ft245_siwu_n),
    .host_rx_data   (host_rx_data),
    .host_rx_valid  (host_rx_valid),
    .host_rx_ready  (host_rx_ready),
    .host_tx_data   (host_tx_data),
    .host_tx_valid  (host_tx_valid),
    .host_tx_ready  (host_tx_ready),
    .cnt_rd         (cnt_rd),
    .cnt_wr         (cnt_wr),
    .err_proto      (err_proto)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ft245_rd_n    = 1'b1;
    ft245_wr_n    = 1'b1;
    ft245_oe_n    = 1'b1;
    ft245_siwu_n  = 1'b1;
    host_rx_valid = 1'b0;
    host_tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ft245_rxf_n !== 1'b1) begin n_fail++; $display("FAIL rst_rxf_n: got %b want 1", ft245_rxf_n); end
    n_checks++; if (ft245_txe_n !== 1'b1) begin n_fail++; $display("FAIL rst_txe_n: got %b want 1", ft245_txe_n); end
    n_checks++; if (ft245_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe: got %b want 0", ft245_data_oe); end
    n_checks++; if (ft245_data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h want 00", ft245_data_out); end
    n_checks++; if (host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", host_tx_valid); end
    n_checks++; if (cnt_rd !== 32'd0 || cnt_wr !== 32'd0) begin n_fail++; $display("FAIL rst_counters: got rd=%0d wr=%0d want 0/0", cnt_rd, cnt_wr); end
    n_checks++; if (err_proto !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_proto); end
    n_checks++; if (host_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 1", host_rx_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++; if (ft245_txe_n !== 1'b0) begin n_fail++; $display("FAIL first_edge_txe_n: got %b want 0", ft245_txe_n); end
    n_checks++; if (ft245_rxf_n !== 1'b1) begin n_fail++; $display("FAIL first_edge_rxf_n: got %b want 1", ft245_rxf_n); end
  endtask

  task automatic test_master_read();
    do_reset();
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h11; step();
    host_rx_data  = 8'h22; step();
    host_rx_data  = 8'h33; step();
    host_rx_valid = 1'b0;
    n_checks++; if (ft245_rxf_n !== 1'b0) begin n_fail++; $display("FAIL rd_rxf_low: got %b want 0", ft245_rxf_n); end
    n_checks++; if (ft245_data_out !== 8'h11) begin n_fail++; $display("FAIL rd_show_ahead: got %h want 11", ft245_data_out); end
    ft245_oe_n = 1'b0;
    step();
    n_checks++; if (ft245_data_oe !== 1'b1) begin n_fail++; $display("FAIL rd_data_oe: got %b want 1", ft245_data_oe); end
    ft245_rd_n = 1'b0;
    n_checks++; if (ft245_data_out !== 8'h11) begin n_fail++; $display("FAIL rd_byte0: got %h want 11", ft245_data_out); end
    step();
    n_checks++; if (ft245_data_out !== 8'h22) begin n_fail++; $display("FAIL rd_byte1: got %h want 22", ft245_data_out); end
    step();
    n_checks++; if (ft245_data_out !== 8'h33 || ft245_rxf_n !== 1'b0) begin n_fail++; $display("FAIL rd_byte2: got %h rxf_n=%b want 33 rxf_n=0", ft245_data_out, ft245_rxf_n); end
    step();
    n_checks++; if (ft245_rxf_n !== 1'b1) begin n_fail++; $display("FAIL rd_rxf_after_last: got %b want 1", ft245_rxf_n); end
    n_checks++; if (cnt_rd !== 32'd3) begin n_fail++; $display("FAIL rd_cnt: got %0d want 3", cnt_rd); end
    step();
    n_checks++; if (cnt_rd !== 32'd3 || err_proto !== 1'b0) begin n_fail++; $display("FAIL rd_overread: got cnt=%0d err=%b want 3/0", cnt_rd, err_proto); end
    ft245_rd_n = 1'b1;
    ft245_oe_n = 1'b1;
    step();
    step();
    n_checks++; if (ft245_data_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_release: got %b want 0", ft245_data_oe); end
  endtask

  task automatic test_write_full();
    do_reset();
    ft245_wr_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ft245_data_in = 8'(i + 1);
      step();
      if (i == 61) begin
        n_checks++; if (ft245_txe_n !== 1'b0) begin n_fail++; $display("FAIL wr_txe_at62: got %b want 0", ft245_txe_n); end
      end
      if (i == 62) begin
        n_checks++; if (ft245_txe_n !== 1'b1 || err_proto !== 1'b0) begin n_fail++; $display("FAIL wr_txe_at63: got txe_n=%b err=%b want 1/0", ft245_txe_n, err_proto); end
      end
    end
    ft245_wr_n = 1'b1;
    n_checks++; if (err_proto !== 1'b1) begin n_fail++; $display("FAIL wr_drop_err: got %b want 1", err_proto); end
    n_checks++; if (cnt_wr !== 32'd63) begin n_fail++; $display("FAIL wr_cnt: got %0d want 63", cnt_wr); end
    n_checks++; if (host_tx_valid !== 1'b1) begin n_fail++; $display("FAIL wr_batch_valid: got %b want 1", host_tx_valid); end
    host_tx_ready = 1'b1;
    for (int j = 0; j < 48; j++) begin
      n_checks++; if (host_tx_data !== 8'(j + 1) || host_tx_valid !== 1'b1) begin n_fail++; $display("FAIL wr_drain_%0d: got %h v=%b want %h v=1", j, host_tx_data, host_tx_valid, 8'(j + 1)); end
      step();
    end
    n_checks++; if (host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL wr_below_batch: got %b want 0", host_tx_valid); end
    n_checks++; if (ft245_txe_n !== 1'b0) begin n_fail++; $display("FAIL wr_txe_after_drain: got %b want 0", ft245_txe_n); end
    host_tx_ready = 1'b0;
  endtask

  task automatic test_siwu_flush();
    do_reset();
    host_tx_ready = 1'b1;
    ft245_wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ft245_data_in = 8'(8'hA0 + i);
      step();
    end
    ft245_wr_n = 1'b1;
    step();
    step();
    n_checks++; if (host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL siwu_hold: got %b want 0", host_tx_valid); end
    n_checks++; if (cnt_wr !== 32'd5) begin n_fail++; $display("FAIL siwu_cnt_wr: got %0d want 5", cnt_wr); end
    ft245_siwu_n = 1'b0;
    step();
    ft245_siwu_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      n_checks++; if (host_tx_valid !== 1'b1 || host_tx_data !== 8'(8'hA0 + j)) begin n_fail++; $display("FAIL siwu_drain_%0d: got %h v=%b want %h v=1", j, host_tx_data, host_tx_valid, 8'(8'hA0 + j)); end
      step();
    end
    n_checks++; if (host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL siwu_empty: got %b want 0", host_tx_valid); end
    ft245_wr_n = 1'b0;
    ft245_data_in = 8'hEE;
    step();
    ft245_wr_n = 1'b1;
    step();
    step();
    n_checks++; if (host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL siwu_latch_clear: got %b want 0", host_tx_valid); end
    host_tx_ready = 1'b0;
  endtask

  task automatic test_proto_err();
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h5A;
    step();
    host_rx_valid = 1'b0;
    ft245_rd_n = 1'b0;
    step();
    ft245_rd_n = 1'b1;
    n_checks++; if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_rd_no_oe: got %b want 1", err_proto); end
    n_checks++; if (ft245_rxf_n !== 1'b0 || ft245_data_out !== 8'h5A || cnt_rd !== 32'd0) begin n_fail++; $display("FAIL proto_rx_kept: got rxf_n=%b dout=%h cnt=%0d want 0/5a/0", ft245_rxf_n, ft245_data_out, cnt_rd); end
    n_checks++; if (cnt_wr !== 32'd6) begin n_fail++; $display("FAIL proto_cnt_wr_pre: got %0d want 6", cnt_wr); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (err_proto !== 1'b0 || cnt_rd !== 32'd0 || cnt_wr !== 32'd0) begin n_fail++; $display("FAIL proto_rst_clear: got err=%b rd=%0d wr=%0d want 0/0/0", err_proto, cnt_rd, cnt_wr); end
    n_checks++; if (ft245_rxf_n !== 1'b1) begin n_fail++; $display("FAIL proto_rst_rxf: got %b want 1", ft245_rxf_n); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h01;
    step();
    host_rx_valid = 1'b0;
    ft245_oe_n = 1'b0;
    step();
    ft245_rd_n    = 1'b0;
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h02;
    step();
    host_rx_valid = 1'b0;
    n_checks++; if (ft245_rxf_n !== 1'b0 || ft245_data_out !== 8'h02 || cnt_rd !== 32'd1) begin n_fail++; $display("FAIL b2b_same_edge: got rxf_n=%b dout=%h cnt=%0d want 0/02/1", ft245_rxf_n, ft245_data_out, cnt_rd); end
    step();
    n_checks++; if (ft245_rxf_n !== 1'b1 || cnt_rd !== 32'd2) begin n_fail++; $display("FAIL b2b_count_one: got rxf_n=%b cnt=%0d want 1/2", ft245_rxf_n, cnt_rd); end
    ft245_rd_n = 1'b1;
    host_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_rx_data = 8'(8'h40 + i);
      step();
    end
    ft245_rd_n = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ft245_rxf_n !== 1'b1 || ft245_data_oe !== 1'b0 || ft245_data_out !== 8'h00) begin n_fail++; $display("FAIL b2b_async_rst: got rxf_n=%b oe=%b dout=%h want 1/0/00", ft245_rxf_n, ft245_data_oe, ft245_data_out); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    n_checks++; if (ft245_rxf_n !== 1'b1 || ft245_txe_n !== 1'b0) begin n_fail++; $display("FAIL b2b_post_rst: got rxf_n=%b txe_n=%b want 1/0", ft245_rxf_n, ft245_txe_n); end
  endtask

  initial begin
    test_reset();
    test_master_read();
    test_write_full();
    test_siwu_flush();
    test_proto_err();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcileech_ft245_dev.md
PCILEECH_FT245_DEV -- requirements
Module: pcileech_ft245_dev

Interface
REQ-001 SHALL have parameter PARAM_DEPTH_LOG2, default 6, meaning log2 of byte depth of each internal FIFO (RX and TX, 64 B each).
REQ-002 SHALL have parameter PARAM_SIWU_EN, default 1, meaning 1 = ft245_siwu_n low flushes the TX FIFO to the host side without waiting for a batch.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as the codebase names them: clk and rst.
REQ-004 Port list, one per line (name, direction, width, meaning):
- clk  in  1  single clock, equal to the FT245 bus clock.
- rst  in  1  asynchronous active-high reset.
- ft245_data_in  in  8  byte driven by the FT245 master.
- ft245_data_out  out  8  byte presented to the master.
- ft245_data_oe  out  1  drive enable for ft245_data_out.
- ft245_rxf_n  out  1  low = RX FIFO holds data.
- ft245_txe_n  out  1  low = TX FIFO has space.
- ft245_rd_n  in  1  master read strobe.
- ft245_wr_n  in  1  master write strobe.
- ft245_oe_n  in  1  master output-enable request.
- ft245_siwu_n  in  1  send-immediate request.
- host_rx_data  in  8  host byte toward the master.
- host_rx_valid  in  1  host byte valid.
- host_rx_ready  out  1  RX FIFO can accept.
- host_tx_data  out  8  byte received from the master.
- host_tx_valid  out  1  host_tx_data valid.
- host_tx_ready  in  1  host accepts byte.
- cnt_rd  out  32  bytes read by the master.
- cnt_wr  out  32  bytes written by the master.
- err_proto  out  1  sticky protocol-violation flag.

Function
REQ-005 Host push SHALL occur on a rising clk edge with host_rx_valid && host_rx_ready; host_rx_ready = RX not full, combinational from count.
REQ-006 Master pop SHALL occur on a rising edge with !ft245_rd_n && !ft245_oe_n && !ft245_rxf_n; ft245_data_out = RX head (show-ahead, data visible without a read cycle), advancing the cycle after each pop.
REQ-007 ft245_data_oe SHALL be a register equal to !ft245_oe_n from the previous edge, giving the one-cycle bus turnaround.
REQ-008 ft245_rxf_n SHALL be registered as (rx_count_next == 0), so it deasserts in the same cycle the last byte is popped; no over-read is possible.
REQ-009 Master write SHALL occur on an edge with !ft245_wr_n && !ft245_txe_n, capturing ft245_data_in.
REQ-010 ft245_txe_n SHALL be registered as (tx_count_next == 2^PARAM_DEPTH_LOG2 - 1) || full, leaving one byte of slack for a write already in flight.
REQ-011 With PARAM_SIWU_EN=0, host_tx_valid SHALL be TX-not-empty.
REQ-012 With PARAM_SIWU_EN=1, host_tx_valid SHALL be held low until the count reaches >= 16 or a siwu flush is latched; the flush latch sets on !ft245_siwu_n and clears when TX is empty.
REQ-013 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged and is legal when the FIFO is full or empty only if the pop side is valid.
REQ-014 Pointers SHALL wrap modulo 2^PARAM_DEPTH_LOG2; the count is PARAM_DEPTH_LOG2+1 bits wide.
REQ-015 cnt_rd and cnt_wr SHALL increment by 1 per accepted master pop or write and wrap at 2^32.
REQ-016 err_proto SHALL set, and stay set until reset, on any edge where any of these holds:
- !rd_n && oe_n;
- !rd_n && !wr_n;
- !wr_n && !oe_n;
- !wr_n && txe_n (write dropped).
REQ-017 A read strobe while rxf_n is high SHALL be ignored without error; the FIFO is unchanged.

Reset
REQ-018 On rst, asynchronously and without waiting for clk, the block SHALL drive:
- ft245_rxf_n=1, ft245_txe_n=1, ft245_data_oe=0, ft245_data_out=0;
- host_tx_valid=0, cnt_rd=cnt_wr=0, err_proto=0;
- both FIFOs empty and the flush latch clear.
REQ-019 Reset asserted mid-transfer SHALL discard all buffered bytes. After release, ft245_txe_n SHALL go low on the first edge; ft245_rxf_n SHALL stay high until a host push.

Structure
REQ-020 A shared package SHALL hold:
- the FIFO depth default constant;
- the SIWU batch threshold (16);
- a typedef for the 8-bit FT245 byte.
REQ-021 A single sub-module, pcileech_ft245_dev_fifo (synchronous show-ahead FIFO with count output), SHALL be instantiated twice, once for RX and once for TX.

Verification
REQ-022 Push 0x11,0x22,0x33 from host; master drops oe_n, then rd_n one cycle later and holds it -> bytes 0x11,0x22,0x33 on consecutive edges, rxf_n high in the cycle after the third pop, cnt_rd=3.
REQ-023 Master writes 64 bytes back-to-back with host_tx_ready=0 -> txe_n high after 63 accepted bytes, byte 64 dropped, err_proto=1, cnt_wr=63.
REQ-024 PARAM_SIWU_EN=1, master writes 5 bytes -> host_tx_valid stays 0; pulse siwu_n -> 5 bytes drain, then host_tx_valid=0 and the flush latch clears.
REQ-025 Assert rd_n with oe_n high -> err_proto=1, RX FIFO unchanged; toggle rst -> err_proto=0 and both counters 0.
REQ-026 With RX holding 1 byte, a host push and a master pop on the same edge -> rx count stays 1 and rxf_n stays low; assert rst mid-burst -> rxf_n=1 immediately, without waiting for clk.
